forwarding_unit: RTL and testbench



---
 rtl/forwarding_unit.sv | 81 ++++++++
 tb/tb_forwarding_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_unit.sv
// forwarding_unit: ALU operand-forwarding selects for the EX stage plus
// saturating counters of how often each forwarding path is taken.
module forwarding_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  input  logic [4:0]       Rd1,
  input  logic [4:0]       Rd2,
  input  logic             Wb1,
  input  logic             Wb2,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] ex_fwd_cnt,
  output logic [CNT_W-1:0] mem_fwd_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b01;

  logic             w_ex_hit_a;
  logic             w_ex_hit_b;
  logic             w_mem_hit_a;
  logic             w_mem_hit_b;
  logic [1:0]       w_ex_inc;
  logic [1:0]       w_mem_inc;
  logic [CNT_W:0]   w_ex_sum;
  logic [CNT_W:0]   w_mem_sum;
  logic [CNT_W-1:0] w_ex_next;
  logic [CNT_W-1:0] w_mem_next;
  logic [CNT_W-1:0] r_ex_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  // Per-operand select: EX/MEM wins over MEM/WB (newer value); x0 never forwards.
  always_comb begin
    w_ex_hit_a  = Wb1 && (Rd1 != 5'd0) && (Rd1 == Rs1);
    w_ex_hit_b  = Wb1 && (Rd1 != 5'd0) && (Rd1 == Rs2);
    w_mem_hit_a = Wb2 && (Rd2 != 5'd0) && (Rd2 == Rs1);
    w_mem_hit_b = Wb2 && (Rd2 != 5'd0) && (Rd2 == Rs2);

    ForwardA = SEL_RF;
    if (w_ex_hit_a)       ForwardA = SEL_EX;
    else if (w_mem_hit_a) ForwardA = SEL_MEM;

    ForwardB = SEL_RF;
    if (w_ex_hit_b)       ForwardB = SEL_EX;
    else if (w_mem_hit_b) ForwardB = SEL_MEM;
  end

  // Count this cycle's events per path and saturate; one extra sum bit flags overflow.
  always_comb begin
    w_ex_inc  = 2'((ForwardA == SEL_EX))  + 2'((ForwardB == SEL_EX));
    w_mem_inc = 2'((ForwardA == SEL_MEM)) + 2'((ForwardB == SEL_MEM));
    w_ex_sum  = {1'b0, r_ex_cnt}  + (CNT_W+1)'(w_ex_inc);
    w_mem_sum = {1'b0, r_mem_cnt} + (CNT_W+1)'(w_mem_inc);
    w_ex_next  = w_ex_sum[CNT_W]  ? '1 : w_ex_sum[CNT_W-1:0];
    w_mem_next = w_mem_sum[CNT_W] ? '1 : w_mem_sum[CNT_W-1:0];
  end

  // Event counters: async reset, sync clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_cnt  <= '0;
      r_mem_cnt <= '0;
    end else if (cnt_clr) begin
      r_ex_cnt  <= '0;
      r_mem_cnt <= '0;
    end else begin
      r_ex_cnt  <= w_ex_next;
      r_mem_cnt <= w_mem_next;
    end
  end

  assign ex_fwd_cnt  = r_ex_cnt;
  assign mem_fwd_cnt = r_mem_cnt;

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed cases, counter behaviour, saturation
// on a narrow instance, and randomized traffic against a behavioural model.
module tb_forwarding_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst4;
  logic        cnt_clr;
  logic [4:0]  Rs1, Rs2, Rd1, Rd2;
  logic        Wb1, Wb2;
  logic [1:0]  fa, fb, fa4, fb4;
  logic [15:0] ex_cnt, mem_cnt;
  logic [3:0]  ex4, mem4;

  int checks = 0;
  int errors = 0;
  int m_ex   = 0;
  int m_mem  = 0;

  always #5 clk = ~clk;

  forwarding_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2),
    .Wb1(Wb1), .Wb2(Wb2), .cnt_clr(cnt_clr), .ForwardA(fa), .ForwardB(fb),
    .ex_fwd_cnt(ex_cnt), .mem_fwd_cnt(mem_cnt)
  );

  forwarding_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2),
    .Wb1(Wb1), .Wb2(Wb2), .cnt_clr(cnt_clr), .ForwardA(fa4), .ForwardB(fb4),
    .ex_fwd_cnt(ex4), .mem_fwd_cnt(mem4)
  );

  // Reference select straight from the forwarding rule.
  function automatic logic [1:0] ref_sel(input int rs, input int rd1, input int rd2,
                                         input bit wb1, input bit wb2);
    if (wb1 && rd1 != 0 && rd1 == rs) return 2'b10;
    if (wb2 && rd2 != 0 && rd2 == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Advance one rising edge and update the counter model for the main instance.
  task automatic tick();
    logic [1:0] a, b;
    int ne, nm;
    a  = ref_sel(int'(Rs1), int'(Rd1), int'(Rd2), Wb1, Wb2);
    b  = ref_sel(int'(Rs2), int'(Rd1), int'(Rd2), Wb1, Wb2);
    ne = int'(a == 2'b10) + int'(b == 2'b10);
    nm = int'(a == 2'b01) + int'(b == 2'b01);
    @(posedge clk);
    #1;
    if (rst || cnt_clr) begin
      m_ex = 0; m_mem = 0;
    end else begin
      m_ex  = (m_ex + ne > 65535) ? 65535 : m_ex + ne;
      m_mem = (m_mem + nm > 65535) ? 65535 : m_mem + nm;
    end
  endtask

  task automatic set_in(input int rs1, input int rs2, input int rd1, input int rd2,
                        input bit wb1, input bit wb2);
    Rs1 = 5'(rs1); Rs2 = 5'(rs2); Rd1 = 5'(rd1); Rd2 = 5'(rd2);
    Wb1 = wb1; Wb2 = wb2;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; cnt_clr = 1'b0;
    set_in(3, 4, 3, 4, 1'b1, 1'b1);
    #1;
    checks++;
    if (ex_cnt !== 16'd0 || mem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt ex=%0d mem=%0d expected 0/0", ex_cnt, mem_cnt);
    end
    checks++;
    if (fa !== 2'b10 || fb !== 2'b01) begin
      errors++;
      $display("FAIL sel_in_reset A=%b B=%b expected 10/01", fa, fb);
    end
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    m_ex = 0; m_mem = 0;
  endtask

  typedef struct {
    int rs1, rs2, rd1, rd2;
    bit wb1, wb2;
    logic [1:0] ea, eb;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    v[0] = '{1, 2, 3, 4, 1'b0, 1'b0, 2'b00, 2'b00};
    v[1] = '{3, 2, 3, 0, 1'b1, 1'b0, 2'b10, 2'b00};
    v[2] = '{1, 3, 3, 0, 1'b1, 1'b0, 2'b00, 2'b10};
    v[3] = '{4, 2, 0, 4, 1'b0, 1'b1, 2'b01, 2'b00};
    v[4] = '{1, 4, 0, 4, 1'b0, 1'b1, 2'b00, 2'b01};
    v[5] = '{3, 4, 3, 4, 1'b1, 1'b1, 2'b10, 2'b01};
    v[6] = '{5, 5, 5, 5, 1'b1, 1'b1, 2'b10, 2'b10};
    v[7] = '{0, 0, 0, 0, 1'b1, 1'b1, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      set_in(v[i].rs1, v[i].rs2, v[i].rd1, v[i].rd2, v[i].wb1, v[i].wb2);
      #1;
      checks++;
      if (fa !== v[i].ea || fb !== v[i].eb) begin
        errors++;
        $display("FAIL directed_sel[%0d] A=%b B=%b expected %b/%b", i, fa, fb, v[i].ea, v[i].eb);
      end
      tick();
      checks++;
      if (ex_cnt !== 16'(m_ex) || mem_cnt !== 16'(m_mem)) begin
        errors++;
        $display("FAIL directed_cnt[%0d] ex=%0d mem=%0d expected %0d/%0d", i, ex_cnt, mem_cnt, m_ex, m_mem);
      end
    end
  endtask

  task automatic test_counters();
    rst = 1'b1; #1; rst = 1'b0;
    m_ex = 0; m_mem = 0;
    set_in(3, 4, 3, 4, 1'b1, 1'b1);
    repeat (3) tick();
    checks++;
    if (ex_cnt !== 16'd3 || mem_cnt !== 16'd3) begin
      errors++;
      $display("FAIL count_3_edges ex=%0d mem=%0d expected 3/3", ex_cnt, mem_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (ex_cnt !== 16'd0 || mem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clr ex=%0d mem=%0d expected 0/0", ex_cnt, mem_cnt);
    end
    repeat (2) tick();
    checks++;
    if (ex_cnt !== 16'd2 || mem_cnt !== 16'd2) begin
      errors++;
      $display("FAIL recount ex=%0d mem=%0d expected 2/2", ex_cnt, mem_cnt);
    end
    // Assert reset between edges: clear must be immediate.
    rst = 1'b1;
    #1;
    checks++;
    if (ex_cnt !== 16'd0 || mem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_rst ex=%0d mem=%0d expected 0/0", ex_cnt, mem_cnt);
    end
    tick();
    checks++;
    if (ex_cnt !== 16'd0 || mem_cnt !== 16'd0) begin
      errors++;
      $display("FAIL hold_in_rst ex=%0d mem=%0d expected 0/0", ex_cnt, mem_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ex_cnt !== 16'd1 || mem_cnt !== 16'd1) begin
      errors++;
      $display("FAIL resume_after_rst ex=%0d mem=%0d expected 1/1", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_saturation();
    rst4 = 1'b1; #1; rst4 = 1'b0;
    set_in(5, 5, 5, 0, 1'b1, 1'b0);
    repeat (7) tick();
    checks++;
    if (ex4 !== 4'd14) begin
      errors++;
      $display("FAIL sat_preload ex4=%0d expected 14", ex4);
    end
    tick();
    checks++;
    if (ex4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_reach ex4=%0d expected 15", ex4);
    end
    tick();
    checks++;
    if (ex4 !== 4'd15 || mem4 !== 4'd0) begin
      errors++;
      $display("FAIL sat_hold ex4=%0d mem4=%0d expected 15/0", ex4, mem4);
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    for (int i = 0; i < 300; i++) begin
      set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cnt_clr = ($urandom_range(0, 31) == 0);
      #1;
      ea = ref_sel(int'(Rs1), int'(Rd1), int'(Rd2), Wb1, Wb2);
      eb = ref_sel(int'(Rs2), int'(Rd1), int'(Rd2), Wb1, Wb2);
      checks++;
      if (fa !== ea || fb !== eb) begin
        errors++;
        $display("FAIL rand_sel[%0d] A=%b B=%b expected %b/%b", i, fa, fb, ea, eb);
      end
      tick();
      checks++;
      if (ex_cnt !== 16'(m_ex) || mem_cnt !== 16'(m_mem)) begin
        errors++;
        $display("FAIL rand_cnt[%0d] ex=%0d mem=%0d expected %0d/%0d", i, ex_cnt, mem_cnt, m_ex, m_mem);
      end
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_counters();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
